// File: rtl/count_seq_checker_pkg.sv
// Shared types and default sizing for the counter-sequence checker.
package count_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_LOCK_CNT = 4;
    localparam int unsigned ERR_W        = 8;
    localparam int unsigned RUN_W        = 4;

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample/observation bus of the checker; master drives samples, slave reports status.
interface count_seq_checker_if
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             sample_en;
    logic [WIDTH-1:0] din;
    logic             clear;
    logic             locked;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] last_val;

    modport master (
        output sample_en, din, clear,
        input  locked, mismatch, err_cnt, last_val
    );

    modport slave (
        input  sample_en, din, clear,
        output locked, mismatch, err_cnt, last_val
    );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating incrementer with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/count_seq_checker.sv
// Tracks a free-running counter: hunts, acquires LOCK_CNT correct increments, then
// flags every broken increment while locked.
module count_seq_checker
    import count_seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                clk,
    input  logic                rst_n,
    count_seq_checker_if.slave  bus
);
    state_e           r_state;
    state_e           w_state_nxt;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic [RUN_W-1:0] w_run_inc;
    logic [WIDTH-1:0] r_last_val;
    logic [WIDTH-1:0] w_expected;
    logic             w_correct;
    logic             r_locked;
    logic             r_mismatch;
    logic             w_mismatch_nxt;
    logic [ERR_W-1:0] w_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_HUNT;
            r_run      <= '0;
            r_last_val <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= w_run_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
            r_mismatch <= w_mismatch_nxt;
            if (bus.sample_en) begin
                r_last_val <= bus.din;
            end
        end
    end

    // Wrap from all-ones to zero is a legal increment, handled by modular add.
    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_mismatch_nxt = 1'b0;
        w_expected     = r_last_val + WIDTH'(1);
        w_correct      = (bus.din == w_expected);
        w_run_inc      = r_run + RUN_W'(1);
        if (bus.sample_en) begin
            case (r_state)
                ST_HUNT: begin
                    w_run_nxt   = '0;
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_correct) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_W'(LOCK_CNT)) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_correct) begin
                        w_mismatch_nxt = 1'b1;
                        w_run_nxt      = '0;
                        w_state_nxt    = ST_ACQUIRE;
                    end
                end
                default: begin
                    w_run_nxt   = '0;
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (bus.clear),
        .i_inc   (w_mismatch_nxt),
        .o_count (w_err_cnt)
    );

    assign bus.locked   = r_locked;
    assign bus.mismatch = r_mismatch;
    assign bus.err_cnt  = w_err_cnt;
    assign bus.last_val = r_last_val;
endmodule

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 Parameter WIDTH, default 8: width of the observed count value.
REQ-002 Parameter LOCK_CNT, default 4: consecutive correct increments required to declare lock, range 1..15.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, synchronous, active-low.
REQ-005 sample_en  input  1: din sampled on this rising edge when high.
REQ-006 din  input  WIDTH: observed free-running counter value.
REQ-007 clear  input  1: synchronous clear of err_cnt.
REQ-008 locked  output  1: high while state is LOCKED.
REQ-009 mismatch  output  1: one-cycle pulse on a sequence error detected while LOCKED.
REQ-010 err_cnt  output  8: saturating count of mismatch pulses.
REQ-011 last_val  output  WIDTH: most recent sampled din.

Function
REQ-012 FSM states: HUNT, ACQUIRE, LOCKED; the next-value check happens only on cycles with sample_en=1.
REQ-013 Expected value = (last_val + 1) mod 2^WIDTH; 2^WIDTH-1 followed by 0 is correct, never an error.
REQ-014 HUNT, sample_en=1: last_val<=din, run<=0, go ACQUIRE; no check performed.
REQ-015 ACQUIRE, correct sample: run increments; on reaching LOCK_CNT go LOCKED, locked high the following cycle.
REQ-016 ACQUIRE, incorrect sample: run<=0, stay ACQUIRE, no mismatch pulse, err_cnt unchanged.
REQ-017 LOCKED, correct sample: stay LOCKED.
REQ-018 LOCKED, incorrect sample: mismatch=1 for exactly the next cycle, err_cnt+1 (saturating at 255), run<=0, go ACQUIRE.
REQ-019 last_val updates to din on every sample_en=1 cycle in every state, correct or not.
REQ-020 sample_en=0: state, run, last_val, err_cnt hold; mismatch is 0.
REQ-021 clear=1: err_cnt<=0 next cycle; state, run, last_val unaffected.
REQ-022 Simultaneous clear and LOCKED mismatch: mismatch still pulses, err_cnt<=0 (clear wins).
REQ-023 err_cnt at 255 stays 255 on further mismatches.
REQ-024 All outputs registered; mismatch latency one cycle after the sampling edge.

Reset
REQ-025 rst_n=0 at a rising edge: state<=HUNT, run<=0, last_val<=0, err_cnt<=0, locked=0, mismatch=0.
REQ-026 Reset overrides clear, sample_en and any in-progress acquisition or lock; no mismatch pulse results from reset.
REQ-027 After reset release, the first sample_en=1 cycle is treated as a HUNT sample.

Structure
REQ-028 Shared package holds the state typedef (HUNT/ACQUIRE/LOCKED) and the default WIDTH and LOCK_CNT constants.
REQ-029 One sub-module, sat_counter (8-bit saturating incrementer with synchronous clear), implements err_cnt.
REQ-030 Target size 120-400 RTL lines, no memories, single clock domain.

Verification
REQ-031 Reset, then din 10,11,12,13,14 with sample_en=1 -> locked=1 the cycle after 14 is sampled; err_cnt=0.
REQ-032 Locked at din 254, then din 255,0,1 -> no mismatch; locked stays 1.
REQ-033 Locked at din 20, then din 40 -> mismatch pulses 1 cycle, err_cnt=1, locked=0; then 41..44 -> relock.
REQ-034 In ACQUIRE, din 5,6,9,10 -> no mismatch, err_cnt=0, run restarts at 9; lock is reached only after 4 correct increments following 9.
REQ-035 Force 256 LOCKED mismatches -> err_cnt=255 held; a mismatch coincident with clear=1 -> err_cnt=0 and mismatch=1.
REQ-036 Locked, assert rst_n=0 for 1 cycle with sample_en=1 -> state HUNT, last_val=0, locked=0, no mismatch; sample_en gaps hold all state.
